// File: rtl/pipe_reg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_reg_pkg                                                     |
// | Brief    : Shared constants and helpers for the elastic pipeline register.  |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package pipe_reg_pkg;

  localparam int PIPE_REG_MAX_STAGES = 16;

  // Width needed to represent the values 0..n inclusive.
  function automatic int clog2_p1(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_reg_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_reg_stage                                                   |
// | Brief    : One valid/data register of the elastic pipe plus its ready term. |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module pipe_reg_stage #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up_valid,
  input  logic [DATAWIDTH-1:0] up_data,
  input  logic                 dn_ready,
  input  logic                 clear,
  output logic                 valid,
  output logic [DATAWIDTH-1:0] data,
  output logic                 ready
);

  logic                 r_valid;
  logic [DATAWIDTH-1:0] r_data;
  logic                 w_ready;

  // A stage can take a word when empty or when its own word leaves this edge.
  assign w_ready = ~r_valid | dn_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (clear) begin
        r_valid <= 1'b0;
      end else if (w_ready) begin
        r_valid <= up_valid;
      end
      // Data only moves on a real transfer; a clear leaves it untouched.
      if (!clear && w_ready && up_valid) begin
        r_data <= up_data;
      end
    end
  end

  assign valid = r_valid;
  assign data  = r_data;
  assign ready = w_ready;

endmodule
`default_nettype wire

// File: rtl/pipe_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_reg                                                         |
// | Brief    : STAGES-deep elastic pipeline register with valid/ready per stage |
// |            and occupancy count. Define PIPE_REG_FLUSH_EN for a flush port.  |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module pipe_reg
  import pipe_reg_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int STAGES    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATAWIDTH-1:0]          in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATAWIDTH-1:0]          out_data,
  output logic [clog2_p1(STAGES)-1:0]   count
`ifdef PIPE_REG_FLUSH_EN
  ,
  input  logic                          flush
`endif
);

  localparam int c_cnt_w = clog2_p1(STAGES);

  if (STAGES < 1 || STAGES > PIPE_REG_MAX_STAGES) begin : g_bad_stages
    $error("pipe_reg: STAGES must be in 1..%0d", PIPE_REG_MAX_STAGES);
  end

  logic [STAGES-1:0]    w_v;
  logic [DATAWIDTH-1:0] w_d    [STAGES];
  logic [STAGES-1:0]    w_up_v;
  logic [DATAWIDTH-1:0] w_up_d [STAGES];
  logic [STAGES:0]      w_rdy;
  logic                 w_flush;
  logic [c_cnt_w-1:0]   w_count;

`ifdef PIPE_REG_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Ready ripples combinationally from the output back to the input.
  assign w_rdy[STAGES] = out_ready;
  assign in_ready      = w_rdy[0] & ~w_flush;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign w_up_v[g] = in_valid & ~w_flush;
      assign w_up_d[g] = in_data;
    end else begin : g_body
      assign w_up_v[g] = w_v[g-1];
      assign w_up_d[g] = w_d[g-1];
    end

    pipe_reg_stage #(
      .DATAWIDTH (DATAWIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (w_up_v[g]),
      .up_data  (w_up_d[g]),
      .dn_ready (w_rdy[g+1]),
      .clear    (w_flush),
      .valid    (w_v[g]),
      .data     (w_d[g]),
      .ready    (w_rdy[g])
    );
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_count = w_count + c_cnt_w'(w_v[i]);
    end
  end

  assign out_valid = w_v[STAGES-1];
  assign out_data  = w_d[STAGES-1];
  assign count     = w_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pipe_reg                                                      |
// | Brief    : Self-checking bench for pipe_reg (DATAWIDTH=32, STAGES=3).       |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_pipe_reg;

  localparam int DW   = 32;
  localparam int S    = 3;
  localparam int CW   = $clog2(S + 1);
  localparam int NRND = 3000;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
  logic          flush;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int first_cyc;
  logic [DW-1:0] got[$];

  // Model: the pipe is a queue of words, each with the stage index it sits in.
  typedef struct {
    logic [DW-1:0] data;
    int            pos;
  } slot_t;
  slot_t mq[$];

  pipe_reg #(
    .DATAWIDTH (DW),
    .STAGES    (S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
`ifdef PIPE_REG_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update: a word advances one stage per edge unless the stage ahead stays occupied.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
    end else begin
      bit    pop;
      bit    push;
      int    lim;
      slot_t s;
      pop  = (mq.size() > 0) && (mq[0].pos == S - 1) && out_ready;
      push = in_valid && !flush && ((mq.size() < S) || out_ready);
      if (pop) void'(mq.pop_front());
      if (flush) mq.delete();
      lim = S;
      for (int i = 0; i < mq.size(); i++) begin
        mq[i].pos = (mq[i].pos + 1 < lim - 1) ? mq[i].pos + 1 : lim - 1;
        lim = mq[i].pos;
      end
      if (push) begin
        s.data = in_data;
        s.pos  = 0;
        mq.push_back(s);
      end
    end
  end

  always @(posedge clk) cyc++;

  // Compare process: every cycle out of reset, DUT outputs against the model.
  always @(negedge clk) begin
    if (rst) begin
      bit ev;
      ev = (mq.size() > 0) && (mq[0].pos == S - 1);
      check("out_valid", {31'b0, out_valid}, {31'b0, ev});
      check("count", 32'(count), 32'(mq.size()));
      check("in_ready", {31'b0, in_ready},
            {31'b0, ((mq.size() < S) || out_ready) && !flush});
      if (ev) check("out_data", out_data, mq[0].data);
    end
  end

  // Output monitor: words that leave the pipe on the coming edge.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) got.push_back(out_data);
    if (rst && out_valid && out_data == 32'h1 && first_cyc < 0) first_cyc = cyc;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [DW-1:0] w);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_data  = w;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      step();
      n++;
    end
    check("push accepted", {31'b0, acc}, 32'h1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int errs;
    int sent;
    bit acc;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    first_cyc = -1;
    repeat (3) step();
    check("rst out_valid", {31'b0, out_valid}, 32'h0);
    check("rst out_data", out_data, 32'h0);
    check("rst count", 32'(count), 32'h0);
    check("rst in_ready", {31'b0, in_ready}, 32'h1);
    rst = 1'b1;
    step();

    // Reset mid-stream with words held
    out_ready = 1'b0;
    push(32'h55); push(32'h66); push(32'h77);
    check("pre-reset count", 32'(count), 32'h3);
    check("pre-reset out_data", out_data, 32'h55);
    #1 rst = 1'b0;
    #1;
    check("midrst out_valid", {31'b0, out_valid}, 32'h0);
    check("midrst out_data", out_data, 32'h0);
    check("midrst count", 32'(count), 32'h0);
    check("midrst in_ready", {31'b0, in_ready}, 32'h1);
    step();
    rst = 1'b1;
    step();

    // Streaming 1..8 with out_ready held high
    got.delete();
    out_ready = 1'b1;
    first_cyc = -1;
    c0 = cyc;
    for (int k = 1; k <= 8; k++) push(32'(k));
    drain(6);
    check("stream latency", 32'(first_cyc - c0), 32'd3);
    check("stream words", 32'(got.size()), 32'd8);
    for (int k = 0; k < 8 && k < got.size(); k++) check("stream order", got[k], 32'(k + 1));

    // Back-pressure: A,B,C fill, D waits
    got.delete();
    out_ready = 1'b0;
    push(32'hA); push(32'hB); push(32'hC);
    in_valid = 1'b1; in_data = 32'hD;
    @(negedge clk);
    check("bp count", 32'(count), 32'h3);
    check("bp in_ready", {31'b0, in_ready}, 32'h0);
    check("bp out_data", out_data, 32'hA);
    step();
    @(negedge clk);
    check("bp hold out_data", out_data, 32'hA);
    check("bp hold out_valid", {31'b0, out_valid}, 32'h1);
    step();
    out_ready = 1'b1;
    push(32'hD);
    drain(5);
    check("bp words", 32'(got.size()), 32'd4);
    for (int k = 0; k < 4 && k < got.size(); k++) check("bp order", got[k], 32'hA + 32'(k));

    // Full pipe, simultaneous push and pop
    got.delete();
    out_ready = 1'b0;
    push(32'h10); push(32'h11); push(32'h12);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h13 + 32'(k);
      @(negedge clk);
      check("full count", 32'(count), 32'h3);
      check("full in_ready", {31'b0, in_ready}, 32'h1);
      check("full out_data", out_data, 32'h10 + 32'(k));
      step();
    end
    drain(5);
    check("full words", 32'(got.size()), 32'd8);
    for (int k = 0; k < 8 && k < got.size(); k++) check("full order", got[k], 32'h10 + 32'(k));

`ifdef PIPE_REG_FLUSH_EN
    // Flush with the head word leaving on the same edge
    got.delete();
    out_ready = 1'b0;
    push(32'h20); push(32'h21); push(32'h22);
    out_ready = 1'b1;
    flush = 1'b1;
    in_valid = 1'b1; in_data = 32'h23;
    @(negedge clk);
    check("flush in_ready", {31'b0, in_ready}, 32'h0);
    check("flush count before", 32'(count), 32'h3);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush count after", 32'(count), 32'h0);
    check("flush out_valid", {31'b0, out_valid}, 32'h0);
    check("flush delivered", 32'(got.size()), 32'd1);
    if (got.size() > 0) check("flush head", got[0], 32'h20);
    step();
`endif

    // Random valid/ready traffic against the model and an ordering scoreboard
    got.delete();
    void'($urandom(32'd20240607));
    sent = 0;
    in_valid = 1'b0;
    for (int c = 0; c < 40000 && got.size() < NRND; c++) begin
      if (!in_valid && sent < NRND && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = 32'h1000 + 32'(sent);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    errs = 0;
    foreach (got[i]) if (got[i] !== 32'h1000 + 32'(i)) errs++;
    check("rand words", 32'(got.size()), 32'(NRND));
    check("rand order", 32'(errs), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
